// File: rtl/rv_pkg.sv
// Shared definitions for the integer register file write side:
// data width, register addressing and the write request record.
package rv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    // One pending register file write: destination and value.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write requests used to park load results until
// the write port is free. No same-cycle bypass from push to pop.
module wb_fifo
    import rv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  wb_req_t                i_din,
    output wb_req_t                o_dout,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    wb_req_t           r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wrPtr;
    logic [PTR_W-1:0]  r_rdPtr;
    logic [PTR_W:0]    r_count;

    // Storage array; contents need no reset because count gates reads.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wrPtr] <= i_din;
        end
    end

    // Pointers wrap naturally modulo DEPTH; count tracks occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (i_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // DEPTH is a power of two, so the count MSB alone marks full.
    assign o_full  = r_count[PTR_W];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rdPtr];

endmodule

// File: rtl/regfile_writeback.sv
// Write-side sequencer for the register file: merges ALU and load
// results onto the single write port and keeps the pending scoreboard.
module regfile_writeback
    import rv_pkg::*;
#(
    parameter int XLEN  = rv_pkg::XLEN,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_alu_valid,
    input  logic [REG_ADDR_W-1:0]  i_alu_rd,
    input  logic [XLEN-1:0]        i_alu_data,
    input  logic                   i_ld_valid,
    output logic                   o_ld_ready,
    input  logic [REG_ADDR_W-1:0]  i_ld_rd,
    input  logic [XLEN-1:0]        i_ld_data,
    input  logic                   i_issue_valid,
    input  logic [REG_ADDR_W-1:0]  i_issue_rd,
    output logic [NUM_REGS-1:0]    o_busy_mask,
    output logic                   o_wb_enable,
    output logic [REG_ADDR_W-1:0]  o_wb_rd,
    output logic [XLEN-1:0]        o_wb_data,
    output logic [$clog2(DEPTH):0] o_fifo_count
);

    wb_req_t               w_ldReq;
    wb_req_t               w_headReq;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_ldReady;
    logic                  w_push;
    logic                  w_pop;
    logic [NUM_REGS-1:0]   w_busyNext;

    logic                  r_wbEnable;
    logic [REG_ADDR_W-1:0] r_wbRd;
    logic [XLEN-1:0]       r_wbData;
    logic [NUM_REGS-1:0]   r_busy;

    // Loads wait here; the ALU has priority, so the head pops only on an ALU bubble.
    assign w_ldReady = !w_full && !reset;
    assign w_push    = i_ld_valid && w_ldReady;
    assign w_pop     = !i_alu_valid && !w_empty;
    assign w_ldReq   = '{rd: i_ld_rd, data: i_ld_data};

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_ldReq),
        .o_dout  (w_headReq),
        .o_count (o_fifo_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Registered write port: ALU first, then FIFO head, otherwise idle with address/data held.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wbEnable <= 1'b0;
            r_wbRd     <= '0;
            r_wbData   <= '0;
        end else if (i_alu_valid) begin
            r_wbEnable <= (i_alu_rd != '0);
            r_wbRd     <= i_alu_rd;
            r_wbData   <= i_alu_data;
        end else if (w_pop) begin
            r_wbEnable <= (w_headReq.rd != '0);
            r_wbRd     <= w_headReq.rd;
            r_wbData   <= w_headReq.data;
        end else begin
            r_wbEnable <= 1'b0;
        end
    end

    // Scoreboard update: retire the register being written, then mark the new producer so it wins a collision.
    always_comb begin
        w_busyNext = r_busy;
        if (r_wbEnable) begin
            w_busyNext[r_wbRd] = 1'b0;
        end
        if (i_issue_valid && (i_issue_rd != '0)) begin
            w_busyNext[i_issue_rd] = 1'b1;
        end
        w_busyNext[0] = 1'b0;
    end

    // Scoreboard state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busyNext;
        end
    end

    assign o_ld_ready  = w_ldReady;
    assign o_busy_mask = r_busy;
    assign o_wb_enable = r_wbEnable;
    assign o_wb_rd     = r_wbRd;
    assign o_wb_data   = r_wbData;

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed scenarios followed
// by randomized traffic, all compared against a queue-based reference model.
module tb_regfile_writeback;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } item_t;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   aluValid;
    logic [4:0]             aluRd;
    logic [XLEN-1:0]        aluData;
    logic                   ldValid;
    logic                   ldReady;
    logic [4:0]             ldRd;
    logic [XLEN-1:0]        ldData;
    logic                   issueValid;
    logic [4:0]             issueRd;
    logic [31:0]            busyMask;
    logic                   wbEnable;
    logic [4:0]             wbRd;
    logic [XLEN-1:0]        wbData;
    logic [$clog2(DEPTH):0] fifoCount;

    int tests  = 0;
    int failed = 0;

    // Reference model state
    item_t           mQueue[$];
    logic [31:0]     mBusy;
    logic            mEn;
    logic [4:0]      mRd;
    logic [XLEN-1:0] mData;

    regfile_writeback #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_alu_valid   (aluValid),
        .i_alu_rd      (aluRd),
        .i_alu_data    (aluData),
        .i_ld_valid    (ldValid),
        .o_ld_ready    (ldReady),
        .i_ld_rd       (ldRd),
        .i_ld_data     (ldData),
        .i_issue_valid (issueValid),
        .i_issue_rd    (issueRd),
        .o_busy_mask   (busyMask),
        .o_wb_enable   (wbEnable),
        .o_wb_rd       (wbRd),
        .o_wb_data     (wbData),
        .o_fifo_count  (fifoCount)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idleInputs();
        aluValid   = 1'b0;
        aluRd      = '0;
        aluData    = '0;
        ldValid    = 1'b0;
        ldRd       = '0;
        ldData     = '0;
        issueValid = 1'b0;
        issueRd    = '0;
    endtask

    // Compare every observable output against the model after an edge
    task automatic checkOutput();
        chk("wb_enable", 64'(wbEnable), 64'(mEn));
        chk("busy_mask", 64'(busyMask), 64'(mBusy));
        chk("fifo_count", 64'(fifoCount), 64'(mQueue.size()));
        chk("ld_ready", 64'(ldReady), 64'(!reset && (mQueue.size() < DEPTH)));
        if (mEn) begin
            chk("wb_rd", 64'(wbRd), 64'(mRd));
            chk("wb_data", 64'(wbData), 64'(mData));
        end
    endtask

    // Advance one clock: predict the post-edge state from the rules, then compare
    task automatic applyStimulus();
        bit    ready;
        item_t it;
        ready = !reset && (mQueue.size() < DEPTH);
        if (reset) begin
            mQueue.delete();
            mBusy = '0;
            mEn   = 1'b0;
            mRd   = '0;
            mData = '0;
        end else begin
            if (mEn) mBusy[mRd] = 1'b0;
            if (issueValid && issueRd != 0) mBusy[issueRd] = 1'b1;
            if (aluValid) begin
                mEn   = (aluRd != 0);
                mRd   = aluRd;
                mData = aluData;
            end else if (mQueue.size() > 0) begin
                it    = mQueue.pop_front();
                mEn   = (it.rd != 0);
                mRd   = it.rd;
                mData = it.data;
            end else begin
                mEn = 1'b0;
            end
            if (ldValid && ready) begin
                it.rd   = ldRd;
                it.data = ldData;
                mQueue.push_back(it);
            end
        end
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        reset = 1'b1;
        idleInputs();
        mQueue.delete();
        mBusy = '0;
        mEn   = 1'b0;
        mRd   = '0;
        mData = '0;

        // Initial reset
        applyStimulus();
        applyStimulus();
        chk("reset_wb_rd", 64'(wbRd), 64'd0);
        chk("reset_wb_data", 64'(wbData), 64'd0);
        reset = 1'b0;
        #1;
        chk("ready_after_reset", 64'(ldReady), 64'd1);

        // Reset with traffic: 3 loads held back by rd=0 ALU traffic, busy 4..7
        for (int k = 0; k < 4; k++) begin
            aluValid   = 1'b1;
            aluRd      = 5'd0;
            aluData    = 32'h0;
            issueValid = 1'b1;
            issueRd    = 5'(4 + k);
            ldValid    = (k < 3);
            ldRd       = 5'(10 + k);
            ldData     = 32'(100 + k);
            applyStimulus();
        end
        idleInputs();
        aluValid = 1'b1;
        chk("traffic_count", 64'(fifoCount), 64'd3);
        chk("traffic_busy", 64'(busyMask), 64'h0000_00F0);
        reset = 1'b1;
        #1;
        chk("ready_in_reset", 64'(ldReady), 64'd0);
        applyStimulus();
        chk("rst_count", 64'(fifoCount), 64'd0);
        chk("rst_busy", 64'(busyMask), 64'd0);
        chk("rst_wb_enable", 64'(wbEnable), 64'd0);
        applyStimulus();
        chk("ready_held_in_reset", 64'(ldReady), 64'd0);
        reset = 1'b0;
        idleInputs();
        applyStimulus();

        // ALU write to r5
        issueValid = 1'b1;
        issueRd    = 5'd5;
        applyStimulus();
        idleInputs();
        aluValid = 1'b1;
        aluRd    = 5'd5;
        aluData  = 32'hDEADBEEF;
        applyStimulus();
        chk("alu_wb_enable", 64'(wbEnable), 64'd1);
        chk("alu_wb_rd", 64'(wbRd), 64'd5);
        chk("alu_wb_data", 64'(wbData), 64'hDEADBEEF);
        chk("alu_busy5_set", 64'(busyMask[5]), 64'd1);
        idleInputs();
        applyStimulus();
        chk("alu_busy5_clear", 64'(busyMask[5]), 64'd0);

        // Priority: load r7 queued, ALU r3 then r4 go first
        ldValid = 1'b1;
        ldRd    = 5'd7;
        ldData  = 32'h11;
        applyStimulus();
        idleInputs();
        aluValid = 1'b1;
        aluRd    = 5'd3;
        aluData  = 32'h33;
        applyStimulus();
        chk("prio_first", 64'(wbRd), 64'd3);
        aluRd   = 5'd4;
        aluData = 32'h44;
        applyStimulus();
        chk("prio_second", 64'(wbRd), 64'd4);
        idleInputs();
        applyStimulus();
        chk("prio_third_rd", 64'(wbRd), 64'd7);
        chk("prio_third_data", 64'(wbData), 64'h11);
        applyStimulus();

        // Full: 4 loads with pops blocked, then a 5th offer is refused
        for (int k = 0; k < 5; k++) begin
            aluValid = 1'b1;
            aluRd    = 5'd0;
            ldValid  = 1'b1;
            ldRd     = 5'(20 + k);
            ldData   = 32'(32'hA000 + k);
            applyStimulus();
        end
        chk("full_count", 64'(fifoCount), 64'd4);
        chk("full_ready", 64'(ldReady), 64'd0);
        idleInputs();
        for (int k = 0; k < 5; k++) applyStimulus();

        // Wrap: 6 loads streamed through with pointers wrapping
        for (int k = 0; k < 6; k++) begin
            ldValid = 1'b1;
            ldRd    = 5'(1 + k);
            ldData  = 32'(32'hB000 + k);
            applyStimulus();
        end
        idleInputs();
        for (int k = 0; k < 3; k++) applyStimulus();

        // rd=0 results never enable a write
        aluValid = 1'b1;
        aluRd    = 5'd0;
        aluData  = 32'hFFFF_FFFF;
        applyStimulus();
        chk("rd0_alu_no_write", 64'(wbEnable), 64'd0);
        idleInputs();
        ldValid = 1'b1;
        ldRd    = 5'd0;
        ldData  = 32'h1234;
        issueValid = 1'b1;
        issueRd    = 5'd0;
        applyStimulus();
        idleInputs();
        applyStimulus();
        chk("rd0_ld_no_write", 64'(wbEnable), 64'd0);
        chk("rd0_drained", 64'(fifoCount), 64'd0);
        chk("rd0_busy0", 64'(busyMask[0]), 64'd0);

        // Set/clear collision on r9
        issueValid = 1'b1;
        issueRd    = 5'd9;
        applyStimulus();
        idleInputs();
        aluValid = 1'b1;
        aluRd    = 5'd9;
        aluData  = 32'h99;
        applyStimulus();
        idleInputs();
        issueValid = 1'b1;
        issueRd    = 5'd9;
        applyStimulus();
        chk("collision_busy9", 64'(busyMask[9]), 64'd1);
        idleInputs();
        applyStimulus();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            reset      = ($urandom_range(63) == 0);
            aluValid   = ($urandom_range(2) == 0);
            aluRd      = 5'($urandom);
            aluData    = $urandom;
            ldValid    = $urandom_range(1);
            ldRd       = 5'($urandom);
            ldData     = $urandom;
            issueValid = $urandom_range(1);
            issueRd    = 5'($urandom);
            applyStimulus();
        end
        reset = 1'b0;
        idleInputs();
        for (int k = 0; k < 6; k++) applyStimulus();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Write-side sequencer for the 32×32 integer register file. It merges single-cycle ALU results with variable-latency load results and issues at most one registered write per cycle to the register file write port (rd / write_enable / write_data). It also keeps a per-register pending scoreboard so decode can stall on read-after-write hazards. It sits between execute/memory and the register file, as the writer counterpart to the register file's read ports.

## Interface
- XLEN, 32: data width.
- DEPTH, 4: load-result FIFO depth. Must be a power of 2 and ≥2.

- clk  in  1  clock.
- reset  in  1  reset; synchronous, active-high.
- alu_valid  in  1  ALU result valid this cycle. No back-pressure; always accepted.
- alu_rd  in  5  ALU destination register.
- alu_data  in  XLEN  ALU result.
- ld_valid  in  1  load result offered.
- ld_ready  out  1  load result can be accepted. Combinational: count<DEPTH and !reset.
- ld_rd  in  5  load destination register.
- ld_data  in  XLEN  load result.
- issue_valid  in  1  decode issued an instruction that writes issue_rd.
- issue_rd  in  5  register to mark pending.
- busy_mask  out  32  scoreboard, one bit per register. Bit 0 is always 0.
- wb_enable  out  1  register file write enable (registered).
- wb_rd  out  5  register file write address (registered).
- wb_data  out  XLEN  register file write data (registered).
- fifo_count  out  $clog2(DEPTH)+1  load FIFO occupancy.

## Operation
- Load handshake: an entry is pushed when ld_valid && ld_ready at a clock edge.
- Per-cycle selection, in strict priority:
  1. alu_valid=1: {alu_rd, alu_data} goes into wb_* at the next edge. The FIFO does not pop.
  2. Otherwise, if the FIFO is non-empty: pop the head and load it into wb_*.
  3. Otherwise: wb_enable←0. wb_rd and wb_data hold their previous values.
- rd=0 results still consume their slot (a FIFO pop, if applicable), but wb_enable←0 for them.
- A push and a pop in the same cycle are both legal. count is unchanged. A push into an empty FIFO is not bypassed to the pop side in the same cycle.
- Scoreboard, evaluated at each edge:
  - If wb_enable=1, clear bit wb_rd.
  - If issue_valid=1 and issue_rd≠0, set bit issue_rd.
  - If both target the same register, the set wins (a new producer is in flight).
- Upstream guarantees alu_valid has bubbles whenever the FIFO is non-empty. Load starvation is not detected.
- Reset mid-operation: FIFO contents are discarded, count←0, busy_mask←0, wb_enable←0, wb_rd←0, wb_data←0. ld_ready=0 while reset is high.

## Timing
- ALU path: sampled at edge T0 → wb_enable=1 in the cycle after T0 → register file writes at T1. busy bit clears at T1, so busy=0 and the new data become visible together.
- Load path: pushed at T0 → earliest pop in the cycle after T0 (if alu_valid=0) → wb_* loaded at T1 → register file writes at T2.
- Throughput: one write per cycle.
- Full: ld_ready deasserts once count=DEPTH, even if a pop occurs that cycle (no same-cycle pass-through).
- FIFO pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count is one bit wider to distinguish full from empty.

## Structure
- Shared package rv_pkg holds:
  - XLEN, REG_ADDR_W=5, NUM_REGS=32.
  - Typedef wb_req_t {rd[4:0], data[XLEN-1:0]}.
- Sub-module wb_fifo: synchronous FIFO of wb_req_t.
  - Parameter DEPTH.
  - Ports: push, pop, din, dout, count, full, empty.
- The top level contains the priority select, the wb_* output registers, and the scoreboard.

## Test plan
- Reset with traffic present: assert reset while the FIFO holds 3 entries and busy_mask=0x0000_00F0 → next cycle count=0, busy_mask=0, wb_enable=0, ld_ready=0 until reset drops.
- ALU write: issue_rd=5, then alu_valid with rd=5, data=0xDEADBEEF → wb_enable=1, wb_rd=5, wb_data=0xDEADBEEF one cycle later; busy bit 5 clears the cycle after that.
- Priority: load rd=7 data=0x11 pushed, followed by 2 back-to-back ALU cycles (rd=3, rd=4) → writes appear in order 3, 4, 7 on consecutive cycles.
- Full and wrap: push 4 loads with no pops → ld_ready=0 and count=4. Drain, then push 6 more → all 6 written in order with correct data across pointer wrap.
- rd=0: ALU result rd=0 data=0xFFFF_FFFF and load rd=0 → wb_enable never asserts, the FIFO still drains, and busy_mask bit 0 stays 0.
- Set/clear collision: wb_enable=1 with wb_rd=9 on the same edge as issue_valid with issue_rd=9 → busy bit 9 remains 1.
